// File: rtl/qcldpc_enc_scheduler.sv
// Column scheduler for a QC-LDPC encoder: issues information columns to the
// shifter bank and times parity-accumulator enables through a fixed delay line.
module qcldpc_enc_scheduler #(
  parameter int NUM_Z           = 3,
  parameter int NUM_INFO_BLKS   = 20,
  parameter int NUM_PARITY_BLKS = 4,
  parameter int PIPE_LAT        = 7,
  localparam int ADDRW = $clog2(NUM_Z * NUM_INFO_BLKS * NUM_PARITY_BLKS),
  localparam int CW    = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_Z-1:0] req_z,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ADDRW-1:0] rom_addr,
  output logic             shft_valid,
  output logic             acc_en,
  output logic             acc_clr,
  output logic [CW-1:0]    col_idx,
  output logic             busy,
  output logic             done,
  output logic             err_z
);

  localparam int ZW = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;
  localparam logic [CW-1:0]    LAST_COL = CW'(NUM_INFO_BLKS - 1);
  localparam logic [ADDRW-1:0] Z_STRIDE = ADDRW'(NUM_INFO_BLKS * NUM_PARITY_BLKS);
  localparam logic [ADDRW-1:0] C_STRIDE = ADDRW'(NUM_PARITY_BLKS);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [ZW-1:0]      z_idx, z_sel;
  logic               z_onehot;
  logic               accept;
  logic [PIPE_LAT-1:0] dly_v, dly_c, dly_l;
  logic               acc_last;

  always_comb begin
    z_onehot = $onehot(req_z);
    z_sel    = '0;
    for (int i = 0; i < NUM_Z; i++) begin
      if (req_z[i]) z_sel = ZW'(i);
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = (state == S_FEED);
    shft_valid = (state == S_FEED) && in_valid;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    accept     = (state == S_IDLE) && start && z_onehot;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_FEED;
      S_FEED:  if (shft_valid && col_idx == LAST_COL) state_nxt = S_DRAIN;
      S_DRAIN: if (acc_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rom_addr = ADDRW'(z_idx) * Z_STRIDE + ADDRW'(col_idx) * C_STRIDE;
  assign acc_en   = dly_v[PIPE_LAT-1];
  assign acc_clr  = dly_c[PIPE_LAT-1];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      z_idx    <= '0;
      col_idx  <= '0;
      err_z    <= 1'b0;
      dly_v    <= '0;
      dly_c    <= '0;
      dly_l    <= '0;
      acc_last <= 1'b0;
    end else begin
      state <= state_nxt;
      err_z <= (state == S_IDLE) && start && !z_onehot;
      if (accept) begin
        z_idx   <= z_sel;
        col_idx <= '0;
      end else if (shft_valid && col_idx != LAST_COL) begin
        col_idx <= col_idx + 1'b1;
      end
      // the last-column tag rides with acc_en so stalls cannot skew DRAIN exit
      dly_v[0] <= shft_valid;
      dly_c[0] <= shft_valid && (col_idx == '0);
      dly_l[0] <= shft_valid && (col_idx == LAST_COL);
      for (int i = 1; i < PIPE_LAT; i++) begin
        dly_v[i] <= dly_v[i-1];
        dly_c[i] <= dly_c[i-1];
        dly_l[i] <= dly_l[i-1];
      end
      acc_last <= dly_v[PIPE_LAT-1] && dly_l[PIPE_LAT-1];
    end
  end

endmodule
